fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage upstream of the instruction memory. Owns the PC register and drives the
//  word address into the combinational instruction memory. Registers the returned word and its PC
//  into an IF/ID output latch. Hands that latch to the decoder over a valid/ready handshake.
//  Redirects (branch/jump) from execute flush the latch. Misaligned or out-of-range fetches raise a
//  sticky fault flag.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  IMEM_DEPTH  1024           instruction memory depth in 32-bit words; addresses beyond it fault
//  NOP_INSTR   32'h0000_0013  instr_o value whenever valid_o=0 (addi x0,x0,0)
// PORTS
//  clk              in   1   system clock, rising edge
//  rst              in   1   asynchronous, active-low reset
//  imem_addr_o      out  32  byte address to instruction memory (= pc_q)
//  imem_rdata_i     in   32  instruction word from memory, combinational from imem_addr_o
//  redirect_i       in   1   taken branch/jump this cycle
//  redirect_pc_i    in   32  target byte address for redirect_i
//  ready_i          in   1   decoder accepts instr_o this cycle
//  valid_o          out  1   instr_o/pc_o hold a live instruction
//  instr_o          out  32  registered instruction word
//  pc_o             out  32  byte address of instr_o
//  fault_o          out  1   sticky fetch fault (misaligned or out-of-range PC)
//  retired_cnt_o    out  32  count of handshakes (valid_o & ready_i), wraps at 2^32
// BEHAVIOUR
//  Reset (rst=0, async) values: pc_q=RESET_PC, valid_o=0, instr_o=NOP_INSTR, pc_o=0, fault_o=0,
//   retired_cnt_o=0, state=BOOT.
//  FSM states and transitions:
//   BOOT:  one cycle after reset release with no fetch; -> RUN.
//   RUN:   normal fetch.
//   FAULT: terminal; left only by reset.
//  Load condition in RUN: load = !valid_o | ready_i. Evaluated in priority order each cycle.
//   1. redirect_i=1 (any state except FAULT):
//      - If redirect_pc_i[1:0]!=0 or redirect_pc_i[31:2]>=IMEM_DEPTH: -> FAULT, fault_o<=1,
//        valid_o<=0.
//      - Otherwise: pc_q<=redirect_pc_i, valid_o<=0, instr_o<=NOP_INSTR.
//      - Latch contents are discarded even if ready_i=1 in the same cycle. No handshake is counted.
//   2. Else if load and pc_q[31:2]>=IMEM_DEPTH: -> FAULT, fault_o<=1, valid_o<=0.
//   3. Else if load: instr_o<=imem_rdata_i, pc_o<=pc_q, valid_o<=1, pc_q<=pc_q+4.
//   4. Else (valid_o=1, ready_i=0): hold pc_q, instr_o, pc_o and valid_o unchanged (stall).
//  Handshake counting:
//   - retired_cnt_o increments on valid_o&ready_i, except in a redirect cycle.
//   - 32'hFFFF_FFFF wraps to 0.
//  Latency and throughput:
//   - Fetch-to-valid latency is 1 cycle.
//   - Sustained throughput is 1 instruction/cycle while ready_i=1.
//   - First valid_o is 2 cycles after reset release (BOOT cycle + load cycle).
//  PC arithmetic: 32-bit unsigned, pc_q+4 wraps modulo 2^32. The range check catches the wrap first.
//  Combinational outputs and don't-care inputs:
//   - imem_addr_o is combinational from pc_q only; there is no input-to-output combinational path.
//   - In BOOT and FAULT, ready_i and imem_rdata_i are ignored.
//   - FAULT holds pc_q, valid_o=0, instr_o=NOP_INSTR.
//  Mid-operation reset: all state returns to reset values immediately; any in-flight instruction
//   is dropped.
// STRUCTURE
//  Shared package (riscv_pkg): RESET_PC default, NOP_INSTR encoding, fetch FSM state encoding
//   (BOOT=2'd0, RUN=2'd1, FAULT=2'd2).
//  One natural sub-module: pc_register (PC flop with next-PC mux: hold / +4 / redirect) with a
//   range/alignment checker. The IF/ID latch, FSM and counter stay in fetch_unit.
// TESTING
//  1. Reset then ready_i=1, memory words 0..3 = 0x0064A423,... -> valid_o rises at 2nd cycle;
//     pc_o=0,4,8,12 on consecutive cycles; retired_cnt_o=4.
//  2. ready_i=0 for 3 cycles with valid_o=1 -> instr_o, pc_o and imem_addr_o stable.
//     Then ready_i=1 -> next pc_o = previous pc_o+4; no instruction skipped or repeated.
//  3. redirect_i=1, redirect_pc_i=0x40, with ready_i=1 in the same cycle -> next cycle valid_o=0,
//     instr_o=0x13, count unchanged. Following cycle pc_o=0x40.
//  4. redirect_pc_i=0x42 -> fault_o=1, valid_o=0 permanently. Assert rst=0 -> fault_o=0,
//     pc restarts at RESET_PC.
//  5. Sequential fetch reaching PC=4*IMEM_DEPTH (0x1000) -> fault_o=1; last valid pc_o=0xFFC.
//  6. Assert rst=0 asynchronously mid-stream (between clock edges) -> valid_o=0 and
//     imem_addr_o=RESET_PC before the next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants, fetch FSM encoding and address-check helpers for the fetch stage.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    function automatic logic addr_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    // Word index compare, so a +4 wrap past 2^32 is caught as out of range first.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned depth);
        return {2'b00, addr[31:2]} >= depth;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory, redirect and decoder-handshake signals.
interface fetch_unit_if;

    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        fault_o;
    logic [31:0] retired_cnt_o;

    modport master (
        output imem_addr_o, valid_o, instr_o, pc_o, fault_o, retired_cnt_o,
        input  imem_rdata_i, redirect_i, redirect_pc_i, ready_i
    );

    modport slave (
        input  imem_addr_o, valid_o, instr_o, pc_o, fault_o, retired_cnt_o,
        output imem_rdata_i, redirect_i, redirect_pc_i, ready_i
    );

endinterface

// File: rtl/fetch_unit_pc_register.sv
// PC flop with hold / +4 / redirect next-PC selection and alignment/range checks.
module pc_register
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic        pc_oob_o,
    output logic        target_bad_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o         = pc_q;
    assign pc_oob_o     = addr_out_of_range(pc_q, IMEM_DEPTH);
    assign target_bad_o = addr_misaligned(redirect_pc_i) | addr_out_of_range(redirect_pc_i, IMEM_DEPTH);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IF/ID output latch, valid/ready handoff to decode, sticky fault.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    fetch_state_e state_q;
    logic         valid_q;
    logic [31:0]  instr_q;
    logic [31:0]  pc_out_q;
    logic         fault_q;
    logic [31:0]  cnt_q;

    logic [31:0]  pc;
    logic         pc_oob;
    logic         target_bad;
    logic         redirect_live;
    logic         load;
    logic         take_redirect;
    logic         advance;
    logic         handshake;

    // A redirect outranks everything, including a same-cycle handshake.
    assign redirect_live = bus.redirect_i && (state_q != FAULT);
    assign load          = (state_q == RUN) && (!valid_q || bus.ready_i);
    assign take_redirect = redirect_live && !target_bad;
    assign advance       = !redirect_live && load && !pc_oob;
    assign handshake     = valid_q && bus.ready_i && !redirect_live;

    pc_register #(
        .RESET_PC   (RESET_PC),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_pc (
        .clk           (clk),
        .rst           (rst),
        .advance_i     (advance),
        .redirect_i    (take_redirect),
        .redirect_pc_i (bus.redirect_pc_i),
        .pc_o          (pc),
        .pc_oob_o      (pc_oob),
        .target_bad_o  (target_bad)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= BOOT;
            valid_q  <= 1'b0;
            instr_q  <= NOP_INSTR;
            pc_out_q <= 32'd0;
            fault_q  <= 1'b0;
            cnt_q    <= 32'd0;
        end else begin
            if (handshake) begin
                cnt_q <= cnt_q + 32'd1;
            end
            case (state_q)
                BOOT, RUN: begin
                    if (redirect_live) begin
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                        if (target_bad) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end else if (state_q == BOOT) begin
                        state_q <= RUN;
                    end else if (load) begin
                        if (pc_oob) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                            valid_q <= 1'b0;
                            instr_q <= NOP_INSTR;
                        end else begin
                            instr_q  <= bus.imem_rdata_i;
                            pc_out_q <= pc;
                            valid_q  <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    valid_q <= 1'b0;
                    instr_q <= NOP_INSTR;
                end
                default: begin
                    state_q <= BOOT;
                    valid_q <= 1'b0;
                    instr_q <= NOP_INSTR;
                end
            endcase
        end
    end

    assign bus.imem_addr_o   = pc;
    assign bus.valid_o       = valid_q;
    assign bus.instr_o       = instr_q;
    assign bus.pc_o          = pc_out_q;
    assign bus.fault_o       = fault_q;
    assign bus.retired_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural model plus directed and random stimulus.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] mem [0:DEPTH-1];

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (DEPTH),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_rdata_i = (bus.imem_addr_o[31:12] == 20'd0) ? mem[bus.imem_addr_o[11:2]] : 32'hDEAD_BEEF;

    // Reference: what the decoder should see, tracked as plain sequential facts.
    logic        m_booted = 1'b0;
    logic        m_fault  = 1'b0;
    logic [31:0] m_pc     = 32'd0;
    logic        m_valid  = 1'b0;
    logic [31:0] m_instr  = NOP;
    logic [31:0] m_pcout  = 32'd0;
    logic [31:0] m_cnt    = 32'd0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_booted = 1'b0;
            m_fault  = 1'b0;
            m_pc     = 32'd0;
            m_valid  = 1'b0;
            m_instr  = NOP;
            m_pcout  = 32'd0;
            m_cnt    = 32'd0;
        end else if (m_fault) begin
            m_valid = 1'b0;
            m_instr = NOP;
        end else if (bus.redirect_i) begin
            m_booted = 1'b1;
            m_valid  = 1'b0;
            m_instr  = NOP;
            if ((bus.redirect_pc_i % 4 != 0) || (bus.redirect_pc_i / 4 >= DEPTH)) begin
                m_fault = 1'b1;
            end else begin
                m_pc = bus.redirect_pc_i;
            end
        end else if (!m_booted) begin
            m_booted = 1'b1;
        end else if (!m_valid || bus.ready_i) begin
            if (m_valid) m_cnt = m_cnt + 1;
            if (m_pc / 4 >= DEPTH) begin
                m_fault = 1'b1;
                m_valid = 1'b0;
                m_instr = NOP;
            end else begin
                m_instr = mem[m_pc / 4];
                m_pcout = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 4;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("valid", {31'd0, bus.valid_o}, {31'd0, m_valid});
        checkOutput("fault", {31'd0, bus.fault_o}, {31'd0, m_fault});
        checkOutput("instr", bus.instr_o, m_instr);
        checkOutput("imem_addr", bus.imem_addr_o, m_pc);
        checkOutput("retired", bus.retired_cnt_o, m_cnt);
        if (m_valid) checkOutput("pc_o", bus.pc_o, m_pcout);
    end

    task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] tgt);
        bus.ready_i       = rdy;
        bus.redirect_i    = redir;
        bus.redirect_pc_i = tgt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] holdInstr;
        logic [31:0] holdPc;
        logic [31:0] holdAddr;
        logic [31:0] cntBefore;
        logic [31:0] lastPc;
        logic        sawFault;

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h0064_A423;
        mem[1] = 32'h00A0_0093;
        mem[2] = 32'h0020_8133;
        mem[3] = 32'hFE00_0EE3;
        bus.ready_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", {31'd0, bus.valid_o}, 32'd0);
        checkOutput("reset_instr", bus.instr_o, 32'h13);
        checkOutput("reset_pc_o", bus.pc_o, 32'd0);
        rst = 1'b1;

        // Streaming from reset with the decoder always ready.
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("boot_valid", {31'd0, bus.valid_o}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("first_valid", {31'd0, bus.valid_o}, 32'd1);
        checkOutput("first_pc", bus.pc_o, 32'd0);
        checkOutput("first_instr", bus.instr_o, 32'h0064_A423);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("pc_4", bus.pc_o, 32'd4);
        checkOutput("instr_1", bus.instr_o, 32'h00A0_0093);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("pc_8", bus.pc_o, 32'd8);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("pc_12", bus.pc_o, 32'd12);
        checkOutput("instr_3", bus.instr_o, 32'hFE00_0EE3);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("retired_4", bus.retired_cnt_o, 32'd4);

        // Stall: everything visible to decode holds still.
        holdInstr = bus.instr_o;
        holdPc    = bus.pc_o;
        holdAddr  = bus.imem_addr_o;
        repeat (3) applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("stall_instr", bus.instr_o, holdInstr);
        checkOutput("stall_pc", bus.pc_o, holdPc);
        checkOutput("stall_addr", bus.imem_addr_o, holdAddr);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("after_stall_pc", bus.pc_o, holdPc + 32'd4);

        // Redirect beats a same-cycle handshake.
        cntBefore = bus.retired_cnt_o;
        applyStimulus(1'b1, 1'b1, 32'h40);
        checkOutput("redir_valid", {31'd0, bus.valid_o}, 32'd0);
        checkOutput("redir_instr", bus.instr_o, 32'h13);
        checkOutput("redir_cnt", bus.retired_cnt_o, cntBefore);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("redir_pc", bus.pc_o, 32'h40);

        // Random traffic, in-range aligned redirects only.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 15) == 0),
                          32'($urandom_range(0, 511)) << 2);
        end

        // Misaligned redirect is terminal until reset.
        applyStimulus(1'b1, 1'b1, 32'h42);
        checkOutput("misalign_fault", {31'd0, bus.fault_o}, 32'd1);
        repeat (4) applyStimulus(1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h80);
        checkOutput("fault_sticky", {31'd0, bus.fault_o}, 32'd1);
        checkOutput("fault_no_valid", {31'd0, bus.valid_o}, 32'd0);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_clears_fault", {31'd0, bus.fault_o}, 32'd0);
        checkOutput("rst_pc", bus.imem_addr_o, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Run off the end of instruction memory.
        lastPc   = 32'hFFFF_FFFF;
        sawFault = 1'b0;
        for (int i = 0; i < 1100 && !sawFault; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0);
            if (bus.valid_o) lastPc = bus.pc_o;
            sawFault = bus.fault_o;
        end
        checkOutput("end_fault", {31'd0, sawFault}, 32'd1);
        checkOutput("end_last_pc", lastPc, 32'h0000_0FFC);

        // Asynchronous reset between edges mid-stream.
        #2 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("pre_async_valid", {31'd0, bus.valid_o}, 32'd1);
        #3 rst = 1'b0;
        #1;
        checkOutput("async_valid", {31'd0, bus.valid_o}, 32'd0);
        checkOutput("async_addr", bus.imem_addr_o, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) applyStimulus(1'b1, 1'b0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
